// File: rtl/super_fetch_if.sv
// Fetch-stage bundle: instruction-memory port plus the IF/ID handshake with decode.
// master = fetch stage, slave = decode stage / memory side.
interface super_fetch_if #(
  parameter int REGI_SIZE  = 16,
  parameter int INSTR_SIZE = 16,
  parameter int PC_BITS    = 10
) ();
  logic                  stall_i;
  logic                  enable_jump_i;
  logic [PC_BITS-1:0]    jump_address_i;
  logic                  flag_end_i;
  logic [PC_BITS-1:0]    imem_addr_o;
  logic                  imem_re_o;
  logic [INSTR_SIZE-1:0] imem_data_i;
  logic [INSTR_SIZE-1:0] instruction_o;
  logic [REGI_SIZE-1:0]  next_pc_o;
  logic                  valid_o;
  logic                  halted_o;

  modport master (
    input  stall_i, enable_jump_i, jump_address_i, flag_end_i, imem_data_i,
    output imem_addr_o, imem_re_o, instruction_o, next_pc_o, valid_o, halted_o
  );

  modport slave (
    output stall_i, enable_jump_i, jump_address_i, flag_end_i, imem_data_i,
    input  imem_addr_o, imem_re_o, instruction_o, next_pc_o, valid_o, halted_o
  );
endinterface

// File: rtl/super_fetch.sv
// Instruction fetch with IF/ID register: PC, 1-entry skid for the one word returning during a stall,
// RUN/DRAIN/HALT control. Address issued in cycle N appears on instruction_o in cycle N+2.
module super_fetch #(
  parameter int                    REGI_SIZE    = 16,
  parameter int                    INSTR_SIZE   = 16,
  parameter int                    PC_BITS      = 10,
  parameter logic [INSTR_SIZE-1:0] NOP_WORD     = 16'h0000,
  parameter int                    DRAIN_CYCLES = 4
) (
  input  logic          clk,
  input  logic          rst,
  super_fetch_if.master bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_HALT} state_e;

  state_e                state_q, state_d;
  logic [PC_BITS-1:0]    pc_q, pc_d;
  logic                  fetch_vld_q, fetch_vld_d;
  logic [PC_BITS-1:0]    fetch_pc_q, fetch_pc_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [INSTR_SIZE-1:0] skid_dat_q, skid_dat_d;
  logic [PC_BITS-1:0]    skid_pc_q, skid_pc_d;
  logic [INSTR_SIZE-1:0] instr_q, instr_d;
  logic [PC_BITS-1:0]    npc_q, npc_d;
  logic                  valid_q, valid_d;
  logic [3:0]            cnt_q, cnt_d;

  assign bus.imem_addr_o   = pc_q;
  assign bus.imem_re_o     = (state_q == ST_RUN) && !bus.stall_i && !rst;
  assign bus.instruction_o = instr_q;
  assign bus.next_pc_o     = {{(REGI_SIZE-PC_BITS){1'b0}}, npc_q};
  assign bus.valid_o       = valid_q;
  assign bus.halted_o      = (state_q == ST_HALT);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    fetch_vld_d = 1'b0;
    fetch_pc_d  = fetch_pc_q;
    skid_vld_d  = skid_vld_q;
    skid_dat_d  = skid_dat_q;
    skid_pc_d   = skid_pc_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    valid_d     = valid_q;
    cnt_d       = cnt_q;

    case (state_q)
      ST_RUN: begin
        if (!bus.stall_i) begin
          if (bus.flag_end_i) begin
            state_d    = ST_DRAIN;
            cnt_d      = 4'(DRAIN_CYCLES);
            skid_vld_d = 1'b0;
            instr_d    = NOP_WORD;
            valid_d    = 1'b0;
          end else if (bus.enable_jump_i) begin
            // The fetch issued this cycle and any returning word belong to the old path.
            pc_d       = bus.jump_address_i;
            skid_vld_d = 1'b0;
            instr_d    = NOP_WORD;
            valid_d    = 1'b0;
          end else begin
            pc_d        = pc_q + 1'b1;
            fetch_vld_d = 1'b1;
            fetch_pc_d  = pc_q;
            if (skid_vld_q) begin
              skid_vld_d = 1'b0;
              instr_d    = skid_dat_q;
              npc_d      = skid_pc_q + 1'b1;
              valid_d    = 1'b1;
            end else if (fetch_vld_q) begin
              instr_d = bus.imem_data_i;
              npc_d   = fetch_pc_q + 1'b1;
              valid_d = 1'b1;
            end else begin
              instr_d = NOP_WORD;
              valid_d = 1'b0;
            end
          end
        end else if (fetch_vld_q && !skid_vld_q) begin
          // No issue happens while stalled, so only one word can ever land here.
          skid_vld_d = 1'b1;
          skid_dat_d = bus.imem_data_i;
          skid_pc_d  = fetch_pc_q;
        end
      end
      ST_DRAIN: begin
        if (!bus.stall_i) begin
          if (cnt_q == 4'd1) state_d = ST_HALT;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      fetch_vld_q <= 1'b0;
      fetch_pc_q  <= '0;
      skid_vld_q  <= 1'b0;
      skid_dat_q  <= NOP_WORD;
      skid_pc_q   <= '0;
      instr_q     <= NOP_WORD;
      npc_q       <= '0;
      valid_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      fetch_vld_q <= fetch_vld_d;
      fetch_pc_q  <= fetch_pc_d;
      skid_vld_q  <= skid_vld_d;
      skid_dat_q  <= skid_dat_d;
      skid_pc_q   <= skid_pc_d;
      instr_q     <= instr_d;
      npc_q       <= npc_d;
      valid_q     <= valid_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_super_fetch.sv
// Bench for super_fetch: directed scenarios then random traffic, checked every cycle against a
// program-order model (next address to deliver, pending bubbles, drain countdown).
module tb_super_fetch;
  localparam int M_RUN = 0, M_DRAIN = 1, M_HALT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  super_fetch_if #(.REGI_SIZE(16), .INSTR_SIZE(16), .PC_BITS(10)) bus ();

  super_fetch #(.REGI_SIZE(16), .INSTR_SIZE(16), .PC_BITS(10),
                .NOP_WORD(16'h0000), .DRAIN_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:1023];
  int checks   = 0;
  int failures = 0;

  // Reference model state
  bit          m_known = 1'b0;
  int          m_state;
  int          m_cnt;
  int          m_pc;
  int          m_bub;
  logic [15:0] m_instr;
  bit          m_valid;
  int          m_npc;
  bit          prev_re   = 1'b0;
  logic [9:0]  prev_addr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input bit r, input bit s, input bit j, input logic [9:0] ja, input bit e);
    @(negedge clk);
    bus.imem_data_i    = prev_re ? mem[prev_addr] : 16'($urandom);
    rst                = r;
    bus.stall_i        = s;
    bus.enable_jump_i  = j;
    bus.jump_address_i = ja;
    bus.flag_end_i     = e;
    #1;
    if (m_known) begin
      chk("valid", 32'(bus.valid_o), 32'(m_valid));
      chk("instr", 32'(bus.instruction_o), 32'(m_instr));
      if (m_valid) chk("next_pc", 32'(bus.next_pc_o), 32'(m_npc));
      chk("halted", 32'(bus.halted_o), 32'(m_state == M_HALT));
      chk("imem_re", 32'(bus.imem_re_o), 32'(!r && !s && m_state == M_RUN));
    end
    prev_re   = bus.imem_re_o;
    prev_addr = bus.imem_addr_o;
    // Advance the model across the coming clock edge
    if (r) begin
      m_known = 1'b1;
      m_state = M_RUN;
      m_pc    = 0;
      m_bub   = 1;
      m_instr = 16'h0000;
      m_valid = 1'b0;
      m_npc   = 0;
    end else if (m_state == M_RUN && !s) begin
      if (e) begin
        m_state = M_DRAIN;
        m_cnt   = 4;
        m_instr = 16'h0000;
        m_valid = 1'b0;
      end else if (j) begin
        m_pc    = int'(ja);
        m_bub   = 1;
        m_instr = 16'h0000;
        m_valid = 1'b0;
      end else if (m_bub > 0) begin
        m_bub--;
        m_instr = 16'h0000;
        m_valid = 1'b0;
      end else begin
        m_instr = mem[m_pc];
        m_valid = 1'b1;
        m_pc    = (m_pc + 1) % 1024;
        m_npc   = m_pc;
      end
    end else if (m_state == M_DRAIN && !s) begin
      if (m_cnt == 1) m_state = M_HALT;
      else            m_cnt--;
    end
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(0, 0, 0, '0, 0);
  endtask

  initial begin
    bit r, s, j, e;
    logic [9:0] ja;
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
    rst = 1'b1;
    bus.stall_i = 1'b0; bus.enable_jump_i = 1'b0; bus.jump_address_i = '0;
    bus.flag_end_i = 1'b0; bus.imem_data_i = '0;

    // Reset, then sequential fetch from 0
    cyc(1, 0, 0, '0, 0);
    cyc(1, 0, 0, '0, 0);
    chk("rst_addr", 32'(bus.imem_addr_o), 32'h0);
    chk("rst_instr", 32'(bus.instruction_o), 32'h0);
    for (int c = 0; c < 3; c++) begin
      cyc(0, 0, 0, '0, 0);
      chk("seq_addr", 32'(bus.imem_addr_o), 32'(c));
    end
    chk("first_word", 32'(bus.instruction_o), 32'(mem[0]));
    chk("first_npc", 32'(bus.next_pc_o), 32'h1);
    // Jump while B is shown
    cyc(0, 0, 1, 10'h150, 0);
    run(4);
    // Stall 3 cycles, then stream resumes without gap
    cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    run(4);
    // Jump to last address: wrap
    cyc(0, 0, 1, 10'h3FF, 0);
    cyc(0, 0, 0, '0, 0);
    chk("wrap_issue", 32'(bus.imem_addr_o), 32'h3FF);
    cyc(0, 0, 0, '0, 0);
    chk("wrap_addr", 32'(bus.imem_addr_o), 32'h0);
    cyc(0, 0, 0, '0, 0);
    chk("wrap_word", 32'(bus.instruction_o), 32'(mem[10'h3FF]));
    chk("wrap_npc", 32'(bus.next_pc_o), 32'h0);
    run(2);
    // End together with jump: end wins, drain 4, then halt
    cyc(0, 0, 1, 10'h020, 1);
    run(6);
    chk("halt_state", 32'(bus.halted_o), 32'h1);
    // Reset out of halt, then reset during drain
    cyc(1, 0, 0, '0, 0);
    run(5);
    cyc(0, 0, 0, '0, 1);
    run(2);
    cyc(1, 0, 0, '0, 0);
    run(4);
    // Reset while stalled with a full skid
    cyc(0, 1, 0, '0, 0);
    cyc(0, 1, 0, '0, 0);
    cyc(1, 1, 0, '0, 0);
    run(4);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      r  = (m_state == M_HALT) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 9) < 3);
      j  = ($urandom_range(0, 19) == 0);
      e  = ($urandom_range(0, 149) == 0);
      ja = ($urandom_range(0, 3) == 0) ? 10'(10'h3FC + $urandom_range(0, 3)) : 10'($urandom);
      cyc(r, s, j, ja, e);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
